add_sub_accum: RTL and testbench
================================

# add_sub_accum

Parametrised two's-complement add/subtract unit with a registered result, valid/ready handshake on both sides, an internal accumulator and a sticky overflow flag. It generalises the fixed 3-bit combinational add/subtract cell to WIDTH bits. It adds pipelined flow control and running-sum capability. It sits in the datapath wherever a streamed sequence of signed add/sub operations, or a running total, is needed.

## Interface
- WIDTH, 8, operand/result width in bits (≥2), two's complement

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept an operation this cycle
- a  in  WIDTH  operand A (ignored when acc_sel=1)
- b  in  WIDTH  operand B
- m  in  1  0 = A+B, 1 = A−B
- acc_sel  in  1  1 = use accumulator as operand A
- clr_acc  in  1  synchronous accumulator clear
- clr_ovf  in  1  synchronous sticky-overflow clear
- out_valid  out  1  result/overflow/carry valid
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered sum/difference
- overflow  out  1  signed overflow of this result
- carry  out  1  carry out of MSB (for subtract: 1 = no borrow)
- acc  out  WIDTH  current accumulator value
- ovf_sticky  out  1  set by any overflowing accepted op

## Operation
- Accept = in_valid && in_ready; in_ready = !out_valid || out_ready (forced 0 while rst_n low).
- Operand A' = clr_acc ? 0 : (acc_sel ? acc : a). B' = m ? ~b : b; carry-in = m.
- Raw sum S = A' + B' + m computed at WIDTH+1 bits; carry = S[WIDTH].
- overflow = (A'[MSB] == B'[MSB]) && (S[MSB] != A'[MSB]).
- On accept: result, overflow and carry are registered, and out_valid is set to 1. acc loads the result (post-saturation if enabled). If overflow=1, ovf_sticky is set to 1.
- clr_acc without accept: acc ← 0 next cycle. clr_acc with accept: operand A is treated as 0 and acc loads the new result.
- clr_ovf: ovf_sticky ← 0. If clr_ovf coincides with an accepted overflowing op, set wins.
- Output register: out_valid is cleared when out_ready=1 and no accept occurs in that cycle. When out_valid && out_ready and a new op is accepted in the same cycle, the output reloads and out_valid stays 1.
- Under backpressure (out_valid && !out_ready), result, overflow and carry hold stable and no op is accepted.
- Inputs are don't-care when no accept occurs.

## Timing
- Reset (async, rst_n=0): result=0, overflow=0, carry=0, out_valid=0, acc=0, ovf_sticky=0, in_ready=0. in_ready=1 from the first cycle after rst_n deasserts.
- Latency: 1 cycle from accept edge to out_valid=1 with the result.
- Throughput: 1 op/cycle while out_ready=1. Back-to-back acc_sel ops chain correctly: each op sees the acc value updated by the previous accept.
- Reset mid-operation: the pending result is discarded, out_valid=0 immediately, and the accumulator is cleared.
- The handshake is registered-output only; no combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.

## Configuration
- ADDSUB_SAT_EN defined: on overflow, result (and acc) saturate. Positive overflow (A'[MSB]=0) → 2^(WIDTH−1)−1; negative overflow → −2^(WIDTH−1). overflow and ovf_sticky still assert; carry reports the raw value.
- ADDSUB_SAT_EN undefined: result wraps modulo 2^WIDTH (pure two's complement), with no saturation logic.

## Test plan
- WIDTH=3, a=001, b=001, m=0, one accept → after 1 cycle: result=010, overflow=0, out_valid=1.
- WIDTH=3, a=011, b=010, m=0 → result=101, overflow=1, ovf_sticky=1. With ADDSUB_SAT_EN: result=011. Then a=110, b=101, m=0 → result=011 (saturated: 100), overflow=1. a=011, b=010, m=1 → result=001, overflow=0, carry=1.
- WIDTH=8 accumulate: clr_acc, then acc_sel=1 with b=10 (add), 10 (add), 5 (sub) back-to-back with out_ready=1 → results 10, 20, 15; acc=15; one result per cycle.
- Backpressure: out_ready=0 with two pending requests → first result holds stable, in_ready=0, second not accepted. out_ready=1 → second accepted in the same cycle, result updates next cycle.
- Simultaneous clr_ovf with an overflowing accept → ovf_sticky=1. clr_ovf alone next cycle → ovf_sticky=0.
- rst_n pulsed low while out_valid=1 and acc≠0 → all outputs 0 asynchronously. After release, the first op (a=3, b=4, m=0, WIDTH=8) gives result=7.

Source files
------------

// File: rtl/add_sub_accum.sv
// -----------------------------------------------------------------------------
// add_sub_accum
//
// Two's-complement add/subtract unit of WIDTH bits. It has a registered result,
// a valid/ready handshake on the input and output sides, a running accumulator
// and a sticky signed-overflow flag.
//
// Operand A is one of three values: the external input a, the accumulator
// (acc_sel=1), or zero (clr_acc=1). Subtraction is done as A + ~B + 1. One
// operation is accepted per cycle while the downstream side is ready.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    operation request
//   in_ready    unit can accept an operation this cycle (0 while in reset)
//   a, b        operands (a is ignored when acc_sel=1)
//   m           0 = A+B, 1 = A-B
//   acc_sel     use the accumulator as operand A
//   clr_acc     clear the accumulator (with an accept: operand A becomes 0)
//   clr_ovf     clear the sticky overflow flag (a new overflow takes priority)
//   out_valid   result/overflow/carry are valid
//   out_ready   downstream accepts the result
//   result      registered sum/difference
//   overflow    signed overflow of this result
//   carry       carry out of the MSB (for subtract: 1 = no borrow)
//   acc         current accumulator value
//   ovf_sticky  set by any accepted operation that overflows
//
// Build option
//   ADDSUB_SAT_EN  When defined, an overflowing result saturates to the most
//                  positive or most negative value. The accumulator loads the
//                  saturated value. Without the macro the result wraps
//                  modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module add_sub_accum #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic             acc_sel,
    input  logic             clr_acc,
    input  logic             clr_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry,
    output logic [WIDTH-1:0] acc,
    output logic             ovf_sticky
);

    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   raw_sum;
    logic             ovf_raw;
    logic [WIDTH-1:0] res_next;

    // in_ready is gated by rst_n so that it reads 0 during reset. When the
    // output is being drained in the same cycle, a new operation can still
    // be accepted.
    assign in_ready = rst_n & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_comb begin
        op_a    = clr_acc ? '0 : (acc_sel ? acc : a);
        op_b    = m ? ~b : b;
        // The sum is computed at WIDTH+1 bits. The top bit is the carry out,
        // and the carry-in of 1 completes the negation of b for subtract.
        raw_sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, m};
        // Signed overflow occurs when both addends have the same sign and
        // the sum has a different sign.
        ovf_raw = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (raw_sum[WIDTH-1] != op_a[WIDTH-1]);
    end

`ifdef ADDSUB_SAT_EN
    // On overflow the sign of A gives the direction. If A is non-negative
    // the true result went above the maximum, so clamp to +max. Otherwise
    // clamp to -min.
    always_comb begin
        res_next = raw_sum[WIDTH-1:0];
        if (ovf_raw) begin
            res_next = op_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign res_next = raw_sum[WIDTH-1:0];
`endif

    // ---------------------------------------------------------------------
    // Output register and handshake
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result    <= '0;
            overflow  <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                result    <= res_next;
                overflow  <= ovf_raw;
                carry     <= raw_sum[WIDTH];
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Accumulator: an accepted op always loads its result. clr_acc has
    // already zeroed operand A on that path, so it only needs its own
    // branch when there is no accept.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= res_next;
        end else if (clr_acc) begin
            acc <= '0;
        end
    end

    // ---------------------------------------------------------------------
    // Sticky overflow: setting it takes priority over clearing it.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (accept && ovf_raw) begin
            ovf_sticky <= 1'b1;
        end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_sub_accum.sv
// -----------------------------------------------------------------------------
// tb_add_sub_accum
//
// Self-checking bench for add_sub_accum with WIDTH=8.
//
// Inputs change 1 time unit after each rising edge. All sampling is done on
// the falling edge.
//
// The reference model works on signed and unsigned integer values:
//   - overflow is detected as a true result outside the signed range;
//   - carry is (a+b >= 2^W) for add, and (a >= b) for subtract;
//   - the result is wrapped or clamped depending on ADDSUB_SAT_EN.
//
// Each accepted operation pushes its expected result into a queue. A separate
// monitor compares the queue head whenever out_valid is high, and pops the
// entry when out_ready completes the transfer.
// -----------------------------------------------------------------------------
module tb_add_sub_accum;

    localparam int W    = 8;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);

    typedef struct packed {
        logic [W-1:0] r;
        logic         o;
        logic         c;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         m;
    logic         acc_sel;
    logic         clr_acc;
    logic         clr_ovf;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflow;
    logic         carry;
    logic [W-1:0] acc;
    logic         ovf_sticky;

    int   tests_run = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];

    // Reference model state
    int   m_acc = 0;
    bit   m_sticky = 0;
    bit   m_ov = 0;

    add_sub_accum #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .m         (m),
        .acc_sel   (acc_sel),
        .clr_acc   (clr_acc),
        .clr_ovf   (clr_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .carry     (carry),
        .acc       (acc),
        .ovf_sticky(ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Computes the expected response from the integer value of each operand.
    function automatic exp_t model_op(input int ua, input int ub, input bit mm);
        int   sa;
        int   sb;
        int   t;
        int   res;
        exp_t e;
        sa  = (ua >= HALF) ? ua - FULL : ua;
        sb  = (ub >= HALF) ? ub - FULL : ub;
        t   = mm ? sa - sb : sa + sb;
        e.o = (t > HALF - 1) || (t < -HALF);
        e.c = mm ? (ua >= ub) : (ua + ub >= FULL);
`ifdef ADDSUB_SAT_EN
        if (t > HALF - 1)
            t = HALF - 1;
        else if (t < -HALF)
            t = -HALF;
`endif
        res = ((t % FULL) + FULL) % FULL;
        e.r = res[W-1:0];
        return e;
    endfunction

    task automatic issue(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic im, input logic ias, input logic ica,
                         input logic ico, input logic iordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        a         = ia;
        b         = ib;
        m         = im;
        acc_sel   = ias;
        clr_acc   = ica;
        clr_ovf   = ico;
        out_ready = iordy;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_result"},     result,     0);
        check({tag, "_overflow"},   overflow,   0);
        check({tag, "_carry"},      carry,      0);
        check({tag, "_out_valid"},  out_valid,  0);
        check({tag, "_acc"},        acc,        0);
        check({tag, "_ovf_sticky"}, ovf_sticky, 0);
        check({tag, "_in_ready"},   in_ready,   0);
    endtask

    // Reference model. It first checks the state the DUT should hold now.
    // Then it advances the model by one cycle using the inputs that will be
    // sampled at the next rising edge.
    initial begin : model_proc
        exp_t e;
        bit   exp_ready;
        int   opa;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_acc    = 0;
                m_sticky = 0;
                m_ov     = 0;
                sb_q.delete();
            end else begin
                exp_ready = !m_ov || out_ready;
                check("acc",        acc,        m_acc);
                check("ovf_sticky", ovf_sticky, m_sticky);
                check("out_valid",  out_valid,  m_ov);
                check("in_ready",   in_ready,   exp_ready);
                if (in_valid && exp_ready) begin
                    opa   = clr_acc ? 0 : (acc_sel ? m_acc : int'(a));
                    e     = model_op(opa, int'(b), m);
                    sb_q.push_back(e);
                    m_acc = int'(e.r);
                    if (e.o)
                        m_sticky = 1;
                    else if (clr_ovf)
                        m_sticky = 0;
                    m_ov  = 1;
                end else begin
                    if (clr_acc)   m_acc    = 0;
                    if (clr_ovf)   m_sticky = 0;
                    if (out_ready) m_ov     = 0;
                end
            end
        end
    end

    // Monitor: compares every presented result with the queue head.
    initial begin : monitor_proc
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    check("result",   result,   sb_q[0].r);
                    check("overflow", overflow, sb_q[0].o);
                    check("carry",    carry,    sb_q[0].c);
                    if (out_ready) begin
                        $display("[TB] result=%0d overflow=%0b carry=%0b", result, overflow, carry);
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stim_proc
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        m         = 1'b0;
        acc_sel   = 1'b0;
        clr_acc   = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        #10 rst_n = 1'b1;

        // Basic arithmetic and overflow boundaries
        issue(1, 8'd1,   8'd1,   0, 0, 0, 0, 1);  // 2
        issue(1, 8'd127, 8'd1,   0, 0, 0, 0, 1);  // positive overflow
        issue(1, 8'h80,  8'hFF,  0, 0, 0, 0, 1);  // -128 + -1: negative overflow
        issue(1, 8'd3,   8'd2,   1, 0, 0, 0, 1);  // 1, no borrow
        issue(1, 8'd2,   8'd3,   1, 0, 0, 0, 1);  // -1, borrow
        issue(1, 8'h80,  8'd1,   1, 0, 0, 0, 1);  // -128 - 1: overflow
        issue(0, 8'd0,   8'd0,   0, 0, 0, 1, 1);  // clr_ovf alone

        // Accumulate chain: clear, then +10, +10, -5 back-to-back
        issue(0, 8'd0,   8'd0,   0, 0, 1, 0, 1);
        issue(1, 8'd99,  8'd10,  0, 1, 0, 0, 1);
        issue(1, 8'd99,  8'd10,  0, 1, 0, 0, 1);
        issue(1, 8'd99,  8'd5,   1, 1, 0, 0, 1);

        // clr_ovf together with an overflowing accept, then clr_ovf alone
        issue(1, 8'd127, 8'd1,   0, 0, 0, 1, 1);
        issue(0, 8'd0,   8'd0,   0, 0, 0, 1, 1);

        // clr_acc together with an accept: operand A is treated as 0
        issue(1, 8'd50,  8'd7,   0, 1, 1, 0, 1);

        // Backpressure: the second request is held off until out_ready
        issue(1, 8'd5,   8'd6,   0, 0, 0, 0, 0);
        issue(1, 8'd9,   8'd9,   0, 0, 0, 0, 0);
        issue(1, 8'd9,   8'd9,   0, 0, 0, 0, 0);
        issue(1, 8'd9,   8'd9,   0, 0, 0, 0, 1);
        issue(0, 8'd0,   8'd0,   0, 0, 0, 0, 1);

        // Reset while a result is pending and acc is non-zero
        issue(1, 8'd0,   8'd20,  0, 1, 0, 0, 0);
        issue(0, 8'd0,   8'd0,   0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("midreset");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        issue(1, 8'd3,   8'd4,   0, 0, 0, 0, 1);  // 7

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            issue($urandom_range(0, 3) != 0,
                  W'($urandom_range(0, FULL - 1)),
                  W'($urandom_range(0, FULL - 1)),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0);
        end

        // Drain
        for (int i = 0; i < 4; i++)
            issue(0, 8'd0, 8'd0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1 check("queue_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
